// File: rtl/vga_pkg.sv
// vga_pkg: shared defaults, pixel format encodings and colour-bar channel bits for the VGA pipeline.
package vga_pkg;
    localparam int DEF_COLOR_WIDTH   = 4;
    localparam int DEF_REZ_MAX_WIDTH = 11;
    typedef enum logic {
        FMT_RGB = 1'b0,
        FMT_BGR = 1'b1
    } fmt_e;
    // bar index bit that lights each channel
    localparam int BAR_R = 0;
    localparam int BAR_G = 1;
    localparam int BAR_B = 2;
endpackage

// File: rtl/vga_color_window_if.sv
// vga_color_window_if: pixel/counter/config inputs and colour outputs of the colour window stage.
interface vga_color_window_if import vga_pkg::*; #(
    parameter int COLOR_WIDTH   = DEF_COLOR_WIDTH,
    parameter int REZ_MAX_WIDTH = DEF_REZ_MAX_WIDTH
);
    logic [3*COLOR_WIDTH-1:0] data;
    logic [REZ_MAX_WIDTH-1:0] count_h;
    logic [REZ_MAX_WIDTH-1:0] count_v;
    logic [REZ_MAX_WIDTH-1:0] h_left_margin;
    logic [REZ_MAX_WIDTH-1:0] h_right_margin;
    logic [REZ_MAX_WIDTH-1:0] v_left_margin;
    logic [REZ_MAX_WIDTH-1:0] v_right_margin;
    logic                     border_en;
    logic [3*COLOR_WIDTH-1:0] border_color;
    logic                     format;
    logic                     test_mode;
    logic [COLOR_WIDTH-1:0]   red;
    logic [COLOR_WIDTH-1:0]   green;
    logic [COLOR_WIDTH-1:0]   blue;
    logic                     active;
    modport master (
        output data, count_h, count_v, h_left_margin, h_right_margin, v_left_margin, v_right_margin,
        output border_en, border_color, format, test_mode,
        input  red, green, blue, active
    );
    modport slave (
        input  data, count_h, count_v, h_left_margin, h_right_margin, v_left_margin, v_right_margin,
        input  border_en, border_color, format, test_mode,
        output red, green, blue, active
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register with synchronous clear.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_color_window.sv
// vga_color_window: gates pixel colour to the display region, with border, channel order and frame-start margins.
// Define VGA_COLOR_TEST_PATTERN_EN to build the colour-bar source selected by test_mode.
module vga_color_window import vga_pkg::*; #(
    parameter int COLOR_WIDTH   = DEF_COLOR_WIDTH,
    parameter int REZ_MAX_WIDTH = DEF_REZ_MAX_WIDTH,
    parameter int PIPE_DEPTH    = 2,
    parameter int BAR_SHIFT     = 6
) (
    input logic               clk,
    input logic               rst,
    vga_color_window_if.slave bus
);
    localparam int CW = COLOR_WIDTH;
    localparam int RW = REZ_MAX_WIDTH;
`ifdef VGA_COLOR_TEST_PATTERN_EN
    localparam int BW = 5;
`else
    localparam int BW = 2;
`endif
    logic [RW-1:0]   hl, hr, vl, vr;
    logic            armed;
    logic            frame_start, in_c, edge_c;
    logic [BW-1:0]   dec_d, dec_q;
    logic [3*CW-1:0] data_fmt, pix;
    assign frame_start = bus.count_h == '0 && bus.count_v == '0;
    // margins only move at frame start so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            {hl, hr, vl, vr} <= '0;
            armed <= 1'b0;
        end else if (frame_start) begin
            {hl, hr, vl, vr} <= {bus.h_left_margin, bus.h_right_margin, bus.v_left_margin, bus.v_right_margin};
            armed <= 1'b1;
        end
    end
    assign in_c = armed && bus.count_h >= hl && bus.count_h <= hr && bus.count_v >= vl && bus.count_v <= vr;
    assign edge_c = in_c && (bus.count_h == hl || bus.count_h == hr || bus.count_v == vl || bus.count_v == vr);
`ifdef VGA_COLOR_TEST_PATTERN_EN
    logic [RW-1:0] rel;
    logic [2:0]    bar;
    assign rel = bus.count_h - hl;
    assign dec_d = {in_c, edge_c, 3'(rel >> BAR_SHIFT)};
    assign bar = dec_q[2:0];
`else
    assign dec_d = {in_c, edge_c};
`endif
    // the first delay stage is the registered region test
    vga_delay_line #(.WIDTH(BW), .DEPTH(PIPE_DEPTH)) u_dly (.clk(clk), .rst(rst), .d(dec_d), .q(dec_q));
    assign data_fmt = fmt_e'(bus.format) == FMT_BGR
        ? {bus.data[CW-1:0], bus.data[2*CW-1:CW], bus.data[3*CW-1:2*CW]} : bus.data;
`ifdef VGA_COLOR_TEST_PATTERN_EN
    assign pix = dec_q[BW-2] && bus.border_en ? bus.border_color
        : bus.test_mode ? {{CW{bar[BAR_B]}}, {CW{bar[BAR_G]}}, {CW{bar[BAR_R]}}} : data_fmt;
`else
    assign pix = dec_q[BW-2] && bus.border_en ? bus.border_color : data_fmt;
`endif
    always_ff @(posedge clk) begin
        if (rst || !dec_q[BW-1]) begin
            {bus.blue, bus.green, bus.red} <= '0;
            bus.active <= 1'b0;
        end else begin
            {bus.blue, bus.green, bus.red} <= pix;
            bus.active <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_color_window.sv
// tb_vga_color_window: directed frame scans checked every cycle against a frame-level model plus literal pins.
module tb_vga_color_window;
    localparam int CW = 4, RW = 11, PD = 2, BS = 6;
    localparam int HT = 410, VT = 16, NC = 60000;
`ifdef VGA_COLOR_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_color_window_if #(.COLOR_WIDTH(CW), .REZ_MAX_WIDTH(RW)) bus ();
    vga_color_window #(.COLOR_WIDTH(CW), .REZ_MAX_WIDTH(RW), .PIPE_DEPTH(PD), .BAR_SHIFT(BS))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0, errors = 0, cyc = 0;
    int cnt [9];
    int ch_a [NC], cv_a [NC], tag_a [NC], bar_a [NC], data_a [NC], bc_a [NC];
    bit rst_a [NC], in_a [NC], edg_a [NC], fmt_a [NC], ben_a [NC], tm_a [NC];
    int m_hl = 0, m_hr = 0, m_vl = 0, m_vr = 0;
    bit m_armed = 1'b0;

    // record this cycle's stimulus and the frame-level region decision, then clock
    task automatic step(input int tag);
        int h, v;
        h = int'(bus.count_h);
        v = int'(bus.count_v);
        ch_a[cyc] = h; cv_a[cyc] = v; tag_a[cyc] = tag; rst_a[cyc] = rst;
        in_a[cyc] = m_armed && h >= m_hl && h <= m_hr && v >= m_vl && v <= m_vr;
        edg_a[cyc] = in_a[cyc] && (h == m_hl || h == m_hr || v == m_vl || v == m_vr);
        bar_a[cyc] = ((h - m_hl) / (1 << BS)) % 8;
        data_a[cyc] = int'(bus.data); bc_a[cyc] = int'(bus.border_color);
        fmt_a[cyc] = bus.format; ben_a[cyc] = bus.border_en; tm_a[cyc] = bus.test_mode;
        if (rst) begin
            m_armed = 1'b0; m_hl = 0; m_hr = 0; m_vl = 0; m_vr = 0;
        end else if (h == 0 && v == 0) begin
            m_armed = 1'b1;
            m_hl = int'(bus.h_left_margin); m_hr = int'(bus.h_right_margin);
            m_vl = int'(bus.v_left_margin); m_vr = int'(bus.v_right_margin);
        end
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic scan(input int tag, input int v0);
        for (int v = v0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                bus.count_v = RW'(v);
                bus.count_h = RW'(h);
                if (tag == 3 && v == 8 && h == 0) bus.h_left_margin = RW'(200);
                rst = (tag == 6 && v == 6 && h == 250);
                step(tag);
            end
        end
    endtask

    task automatic pin(input string nm, input bit a, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        checks++;
        if ({bus.active, bus.red, bus.green, bus.blue} !== {a, r, g, b}) begin
            errors++;
            $display("FAIL pin %s: got act=%0b rgb=%h%h%h, want act=%0b rgb=%h%h%h",
                     nm, bus.active, bus.red, bus.green, bus.blue, a, r, g, b);
        end
    endtask

    function automatic bit at(input int j, input int t, input int v, input int h);
        return tag_a[j] == t && cv_a[j] == v && ch_a[j] == h;
    endfunction

    always @(negedge clk) begin : cmp
        int k, j, d, lo, mi, hi, m;
        bit z, ea;
        logic [3:0] er, eg, eb;
        if (cyc > PD) begin
            k = cyc - 1;
            j = k - PD;
            m = (1 << CW) - 1;
            z = !in_a[j];
            for (int i = j; i <= k; i++) if (rst_a[i]) z = 1'b1;
            ea = !z;
            if (z) begin
                er = 0; eg = 0; eb = 0;
            end else if (edg_a[j] && ben_a[k]) begin
                er = 4'(bc_a[k] & m); eg = 4'((bc_a[k] >> CW) & m); eb = 4'((bc_a[k] >> 2*CW) & m);
            end else if (TP && tm_a[k]) begin
                er = bar_a[j] % 2 == 1 ? 4'hF : 4'h0;
                eg = (bar_a[j] / 2) % 2 == 1 ? 4'hF : 4'h0;
                eb = bar_a[j] / 4 == 1 ? 4'hF : 4'h0;
            end else begin
                d = data_a[k];
                lo = d & m; mi = (d >> CW) & m; hi = (d >> 2*CW) & m;
                er = 4'(fmt_a[k] ? hi : lo); eg = 4'(mi); eb = 4'(fmt_a[k] ? lo : hi);
            end
            checks++;
            if ({bus.active, bus.red, bus.green, bus.blue} !== {ea, er, eg, eb}) begin
                errors++;
                $display("FAIL model cyc=%0d h=%0d v=%0d: got act=%0b r=%h g=%h b=%h, want act=%0b r=%h g=%h b=%h",
                         k, ch_a[j], cv_a[j], bus.active, bus.red, bus.green, bus.blue, ea, er, eg, eb);
            end
            cnt[tag_a[j]] += int'(bus.active);
            if (at(j, 1, 3, 144)) pin("f1_top_left", 1, 4'hC, 4'hB, 4'hA);
            if (at(j, 1, 3, 143)) pin("f1_left_out", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 1, 12, 399)) pin("f1_bot_right", 1, 4'hC, 4'hB, 4'hA);
            if (at(j, 1, 12, 400)) pin("f1_right_out", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 1, 13, 200)) pin("f1_below", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 2, 3, 200)) pin("bd_top", 1, 4'h0, 4'h0, 4'hF);
            if (at(j, 2, 7, 144)) pin("bd_left", 1, 4'h0, 4'h0, 4'hF);
            if (at(j, 2, 7, 399)) pin("bd_right", 1, 4'h0, 4'h0, 4'hF);
            if (at(j, 2, 12, 300)) pin("bd_bottom", 1, 4'h0, 4'h0, 4'hF);
            if (at(j, 2, 7, 200)) pin("bd_inner", 1, 4'hC, 4'hB, 4'hA);
            if (at(j, 3, 10, 150)) pin("hl_old_frame", 1, 4'hC, 4'hB, 4'hA);
            if (at(j, 4, 10, 150)) pin("hl_new_out", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 4, 10, 199)) pin("hl_new_199", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 4, 10, 200)) pin("hl_new_in", 1, 4'hC, 4'hB, 4'hA);
            if (at(j, 5, 7, 450)) pin("inverted", 0, 4'h0, 4'h0, 4'h0);
            if (at(j, 6, 4, 300)) pin("fmt_bgr", 1, 4'hA, 4'hB, 4'hC);
            if (at(j, 6, 7, 300)) pin("after_rst", 0, 4'h0, 4'h0, 4'h0);
`ifdef VGA_COLOR_TEST_PATTERN_EN
            if (at(j, 7, 5, 150)) pin("bar_black", 1, 4'h0, 4'h0, 4'h0);
            if (at(j, 7, 5, 210)) pin("bar_red", 1, 4'hF, 4'h0, 4'h0);
            if (at(j, 7, 5, 280)) pin("bar_green", 1, 4'h0, 4'hF, 4'h0);
            if (at(j, 7, 5, 340)) pin("bar_yellow", 1, 4'hF, 4'hF, 4'h0);
`else
            if (at(j, 7, 5, 210)) pin("bar_ignored", 1, 4'hC, 4'hB, 4'hA);
`endif
        end
    end

    initial begin
        int ec [9];
        ec = '{0, 2560, 2560, 2560, 2000, 0, 872, 2560, 0};
        foreach (cnt[i]) cnt[i] = 0;
        bus.data = 12'hABC; bus.border_color = 12'hF00;
        bus.h_left_margin = RW'(144); bus.h_right_margin = RW'(399);
        bus.v_left_margin = RW'(3); bus.v_right_margin = RW'(12);
        bus.border_en = 1'b0; bus.format = 1'b0; bus.test_mode = 1'b0;
        bus.count_v = RW'(10); bus.count_h = RW'(0);
        rst = 1'b1;
        repeat (3) step(0);
        checks++;
        if ({bus.active, bus.red, bus.green, bus.blue} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got act=%0b rgb=%h%h%h, want all 0", bus.active, bus.red, bus.green, bus.blue);
        end
        rst = 1'b0;
        scan(0, 10);
        scan(1, 0);
        bus.border_en = 1'b1;
        scan(2, 0);
        bus.border_en = 1'b0;
        scan(3, 0);
        scan(4, 0);
        bus.h_left_margin = RW'(500); bus.h_right_margin = RW'(400);
        scan(5, 0);
        bus.h_left_margin = RW'(144); bus.h_right_margin = RW'(399); bus.format = 1'b1;
        scan(6, 0);
        bus.format = 1'b0; bus.test_mode = 1'b1;
        scan(7, 0);
        bus.test_mode = 1'b0;
        for (int h = 0; h < 4; h++) begin
            bus.count_v = RW'(0); bus.count_h = RW'(h);
            step(8);
        end
        @(negedge clk);
        #1;
        for (int t = 0; t < 9; t++) begin
            checks++;
            if (cnt[t] != ec[t]) begin
                errors++;
                $display("FAIL active_count tag%0d: got %0d, want %0d", t, cnt[t], ec[t]);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
